// File: rtl/c499_sec_ingress.sv
// Key-loading and word-buffering ingress for the c499 keyed SEC core.
// Serial key shadow + commit FSM, and a 2-entry valid/ready FIFO of {en, chk, data}.
module c499_sec_ingress #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 8,
  parameter int KEY_W  = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_sdi,
  input  logic              key_shift,
  input  logic              key_commit,
  output logic [KEY_W-1:0]  key_o,
  output logic              key_valid,
  output logic              key_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  input  logic              in_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_chk,
  output logic              out_en
);

  localparam int          ENT_W    = DATA_W + CHK_W + 1;
  localparam logic [3:0]  KEY_CNT  = 4'(KEY_W);
  localparam logic [1:0]  FULL_CNT = 2'(DEPTH);

  typedef enum logic [1:0] {NOKEY, ARMED, PEND} state_t;

  state_t             state, state_n;
  logic [KEY_W-1:0]   shadow;
  logic [3:0]         bit_cnt;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic               wr_ptr, rd_ptr;
  logic [1:0]         count, count_n;
  logic               push, pop;
  logic               commit_ok, apply, reject, shift_en;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (count != 2'd0);
  assign {out_en, out_chk, out_data} = mem[rd_ptr];

  assign commit_ok = key_commit && (bit_cnt == KEY_CNT);
  // Commit wins over a same-cycle shift; PEND ignores both key controls.
  assign reject    = key_commit && !commit_ok && (state != PEND);
  assign shift_en  = key_shift && !key_commit && (state != PEND);

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + 2'd1;
    else if (pop && !push) count_n = count - 2'd1;

    state_n = state;
    apply   = 1'b0;
    case (state)
      NOKEY: begin
        if (commit_ok) begin
          apply   = 1'b1;
          state_n = ARMED;
        end
      end
      ARMED: begin
        if (commit_ok) begin
          if (count == 2'd0 && !push) apply = 1'b1;
          else                        state_n = PEND;
        end
      end
      PEND: begin
        // Old key stays on the core until every buffered word has left.
        if (count == 2'd0) begin
          apply   = 1'b1;
          state_n = ARMED;
        end
      end
      default: state_n = NOKEY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= NOKEY;
      shadow    <= '0;
      bit_cnt   <= '0;
      key_o     <= '0;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_n;
      key_valid <= (state_n != NOKEY);
      key_err   <= reject;
      in_ready  <= (state_n == ARMED) && (count_n != FULL_CNT);
      if (apply) begin
        key_o   <= shadow;
        bit_cnt <= '0;
      end else if (reject) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        shadow <= {shadow[KEY_W-2:0], key_sdi};
        if (bit_cnt != 4'hF) bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      count <= count_n;
      if (push) begin
        mem[wr_ptr] <= {in_en, in_chk, in_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

endmodule

// File: tb/tb_c499_sec_ingress.sv
// Scoreboard bench for c499_sec_ingress: key load/commit rules and FIFO ordering.
module tb_c499_sec_ingress;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_sdi, key_shift, key_commit;
  logic [7:0]  key_o;
  logic        key_valid, key_err;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_chk;
  logic        in_en;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_chk;
  logic        out_en;

  int checks = 0;
  int failures = 0;
  int n_push = 0;
  logic [40:0] sb [$];

  c499_sec_ingress dut (
    .clk(clk), .rst(rst), .key_sdi(key_sdi), .key_shift(key_shift),
    .key_commit(key_commit), .key_o(key_o), .key_valid(key_valid),
    .key_err(key_err), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_chk(in_chk), .in_en(in_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chk(out_chk), .out_en(out_en)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL pop_order got=%h expected=none", {out_en, out_chk, out_data});
        end else begin
          logic [40:0] exp;
          exp = sb.pop_front();
          if ({out_en, out_chk, out_data} !== exp) begin
            failures++;
            $display("FAIL pop_order got=%h expected=%h", {out_en, out_chk, out_data}, exp);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back({in_en, in_chk, in_data});
        n_push++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      key_shift = 1'b1;
      key_sdi   = v[i];
      tick();
    end
    key_shift = 1'b0;
    key_sdi   = 1'b0;
  endtask

  task automatic commit;
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
  endtask

  task automatic drive_word;
    in_valid = 1'b1;
    in_data  = $urandom;
    in_chk   = 8'($urandom);
    in_en    = 1'($urandom);
  endtask

  task automatic wait_drain;
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain left=%0d out_valid=%b expected 0/0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset;
    #1;
    checks += 8;
    if (key_o !== 8'h00)      begin failures++; $display("FAIL rst_key_o got=%h expected=00", key_o); end
    if (key_valid !== 1'b0)   begin failures++; $display("FAIL rst_key_valid got=%b expected=0", key_valid); end
    if (key_err !== 1'b0)     begin failures++; $display("FAIL rst_key_err got=%b expected=0", key_err); end
    if (in_ready !== 1'b0)    begin failures++; $display("FAIL rst_in_ready got=%b expected=0", in_ready); end
    if (out_valid !== 1'b0)   begin failures++; $display("FAIL rst_out_valid got=%b expected=0", out_valid); end
    if (out_data !== 32'h0)   begin failures++; $display("FAIL rst_out_data got=%h expected=0", out_data); end
    if (out_chk !== 8'h0)     begin failures++; $display("FAIL rst_out_chk got=%h expected=0", out_chk); end
    if (out_en !== 1'b0)      begin failures++; $display("FAIL rst_out_en got=%b expected=0", out_en); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_key_load;
    shift_bits(8'hB2, 8);
    checks += 2;
    if (key_valid !== 1'b0) begin failures++; $display("FAIL nokey_valid got=%b expected=0", key_valid); end
    if (in_ready !== 1'b0)  begin failures++; $display("FAIL nokey_ready got=%b expected=0", in_ready); end
    commit();
    checks += 4;
    if (key_o !== 8'hB2)    begin failures++; $display("FAIL load_key_o got=%h expected=b2", key_o); end
    if (key_valid !== 1'b1) begin failures++; $display("FAIL load_key_valid got=%b expected=1", key_valid); end
    if (in_ready !== 1'b1)  begin failures++; $display("FAIL load_in_ready got=%b expected=1", in_ready); end
    if (key_err !== 1'b0)   begin failures++; $display("FAIL load_key_err got=%b expected=0", key_err); end
  endtask

  task automatic test_key_reject;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    shift_bits(8'h15, 5);
    commit();
    checks += 3;
    if (key_err !== 1'b1)   begin failures++; $display("FAIL rej_key_err got=%b expected=1", key_err); end
    if (key_valid !== 1'b0) begin failures++; $display("FAIL rej_key_valid got=%b expected=0", key_valid); end
    if (in_ready !== 1'b0)  begin failures++; $display("FAIL rej_in_ready got=%b expected=0", in_ready); end
    tick();
    checks++;
    if (key_err !== 1'b0)   begin failures++; $display("FAIL rej_err_pulse got=%b expected=0", key_err); end
    shift_bits(8'h5A, 8);
    commit();
    checks += 3;
    if (key_o !== 8'h5A)    begin failures++; $display("FAIL rej_reload_key got=%h expected=5a", key_o); end
    if (key_valid !== 1'b1) begin failures++; $display("FAIL rej_reload_valid got=%b expected=1", key_valid); end
    if (key_err !== 1'b0)   begin failures++; $display("FAIL rej_reload_err got=%b expected=0", key_err); end
  endtask

  task automatic test_backpressure;
    logic [31:0] w0;
    int target, n;
    out_ready = 1'b0;
    drive_word();
    w0 = in_data;
    tick();
    checks += 3;
    if (in_ready !== 1'b1)  begin failures++; $display("FAIL bp_ready1 got=%b expected=1", in_ready); end
    if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_latency got=%b expected=1", out_valid); end
    if (out_data !== w0)    begin failures++; $display("FAIL bp_head got=%h expected=%h", out_data, w0); end
    drive_word();
    tick();
    checks++;
    if (in_ready !== 1'b0)  begin failures++; $display("FAIL bp_full got=%b expected=0", in_ready); end
    drive_word();
    target = n_push + 1;
    tick();
    tick();
    checks += 3;
    if (in_ready !== 1'b0)  begin failures++; $display("FAIL bp_hold_ready got=%b expected=0", in_ready); end
    if (out_data !== w0)    begin failures++; $display("FAIL bp_stable got=%h expected=%h", out_data, w0); end
    if (n_push !== target - 1) begin failures++; $display("FAIL bp_third_blocked got=%0d expected=%0d", n_push, target - 1); end
    out_ready = 1'b1;
    n = 0;
    while (n_push < target && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n_push < target) begin failures++; $display("FAIL bp_third_accept got=%0d expected=%0d", n_push, target); end
    tick();
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_pend_commit;
    int n;
    logic done;
    out_ready = 1'b0;
    drive_word();
    tick();
    drive_word();
    tick();
    in_valid = 1'b0;
    shift_bits(8'h3C, 8);
    commit();
    checks += 3;
    if (key_o !== 8'h5A)    begin failures++; $display("FAIL pend_old_key got=%h expected=5a", key_o); end
    if (in_ready !== 1'b0)  begin failures++; $display("FAIL pend_ready got=%b expected=0", in_ready); end
    if (key_valid !== 1'b1) begin failures++; $display("FAIL pend_valid got=%b expected=1", key_valid); end
    out_ready = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      tick();
      n++;
      if (key_o === 8'h3C) begin
        done = 1'b1;
        checks += 2;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
          failures++;
          $display("FAIL pend_early_key left=%0d out_valid=%b expected 0/0", sb.size(), out_valid);
        end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL pend_rearm got=%b expected=1", in_ready); end
      end else begin
        checks += 2;
        if (key_o !== 8'h5A)   begin failures++; $display("FAIL pend_key_hold got=%h expected=5a", key_o); end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL pend_ready_hold got=%b expected=0", in_ready); end
      end
    end
    checks++;
    if (!done) begin failures++; $display("FAIL pend_apply got=%h expected=3c", key_o); end
  endtask

  task automatic test_shift_commit;
    shift_bits(8'hA5, 8);
    key_shift  = 1'b1;
    key_sdi    = 1'b1;
    key_commit = 1'b1;
    tick();
    key_shift  = 1'b0;
    key_sdi    = 1'b0;
    key_commit = 1'b0;
    checks += 2;
    if (key_o !== 8'hA5)  begin failures++; $display("FAIL sc_key got=%h expected=a5", key_o); end
    if (key_err !== 1'b0) begin failures++; $display("FAIL sc_err got=%b expected=0", key_err); end
    commit();
    checks += 2;
    if (key_err !== 1'b1) begin failures++; $display("FAIL sc_cnt_clear got=%b expected=1", key_err); end
    if (key_o !== 8'hA5)  begin failures++; $display("FAIL sc_key_kept got=%h expected=a5", key_o); end
    tick();
  endtask

  task automatic test_back_to_back;
    int start;
    out_ready = 1'b1;
    start = n_push;
    for (int i = 0; i < 6; i++) begin
      drive_word();
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b expected=1", i, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (n_push !== start + 6) begin failures++; $display("FAIL b2b_rate got=%0d expected=%0d", n_push - start, 6); end
    wait_drain();
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive_word();
    tick();
    drive_word();
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b expected=0", out_valid); end
    if (key_valid !== 1'b0) begin failures++; $display("FAIL mid_key_valid got=%b expected=0", key_valid); end
    if (key_o !== 8'h00)    begin failures++; $display("FAIL mid_key_o got=%h expected=00", key_o); end
    if (in_ready !== 1'b0)  begin failures++; $display("FAIL mid_in_ready got=%b expected=0", in_ready); end
    if (out_data !== 32'h0) begin failures++; $display("FAIL mid_out_data got=%h expected=0", out_data); end
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0)  begin failures++; $display("FAIL mid_nokey_ready got=%b expected=0", in_ready); end
    shift_bits(8'h81, 8);
    commit();
    checks += 2;
    if (in_ready !== 1'b1)  begin failures++; $display("FAIL mid_rearm_ready got=%b expected=1", in_ready); end
    if (key_o !== 8'h81)    begin failures++; $display("FAIL mid_rearm_key got=%h expected=81", key_o); end
  endtask

  initial begin
    rst = 1'b1;
    key_sdi = 1'b0; key_shift = 1'b0; key_commit = 1'b0;
    in_valid = 1'b0; in_data = '0; in_chk = '0; in_en = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_key_load();
    test_key_reject();
    test_backpressure();
    test_pend_commit();
    test_shift_commit();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
